// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I encoding types for the instruction encoder.
//   instr_fmt_e  : instruction format selector (codes 6 and 7 are illegal)
//   OPC_*        : base opcode constants
//   NOP_INSTR    : canonical NOP (addi x0,x0,0) emitted for illegal formats
//   enc_req_t    : one input beat as held in pipeline stage 1
//   imm_fits     : range helper, true when imm[31:msb] is a pure sign extension
package rv32i_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } instr_fmt_e;

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_req_t;

   // All bits from msb upward must equal the sign bit; an arithmetic shift
   // collapses them into a word that is either all zeros or all ones.
   function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
      logic [31:0] hi;
      hi = $unsigned($signed(imm) >>> msb);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational packer, fmt + fields + imm -> RV32I word.
//   fmt/opcode/rd/rs1/rs2/funct3/funct7/imm : beat fields (unused fields ignored)
//   instruction : packed word (truncated packing even when the imm is bad)
//   imm_err     : imm out of range / misaligned for fmt, or fmt illegal
module instr_field_pack
   import rv32i_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic [2:0]           fmt,
   input  logic [6:0]           opcode,
   input  logic [4:0]           rd,
   input  logic [4:0]           rs1,
   input  logic [4:0]           rs2,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic [DataWidth-1:0] imm,
   output logic [DataWidth-1:0] instruction,
   output logic                 imm_err
);

   always_comb begin
      instruction = NOP_INSTR;
      imm_err     = 1'b1;
      case (instr_fmt_e'(fmt))
         FMT_R: begin
            instruction = {funct7, rs2, rs1, funct3, rd, opcode};
            imm_err     = 1'b0;
         end
         FMT_I: begin
            instruction = {imm[11:0], rs1, funct3, rd, opcode};
            imm_err     = !imm_fits(imm, 11);
         end
         FMT_S: begin
            instruction = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            imm_err     = !imm_fits(imm, 11);
         end
         FMT_B: begin
            instruction = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            imm_err     = !imm_fits(imm, 12) || imm[0];
         end
         FMT_U: begin
            instruction = {imm[31:12], rd, opcode};
            imm_err     = (imm[11:0] != 12'h000);
         end
         FMT_J: begin
            instruction = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            imm_err     = !imm_fits(imm, 20) || imm[0];
         end
         default: begin
            // Illegal format codes: emit a harmless NOP flagged as an error.
            instruction = NOP_INSTR;
            imm_err     = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: two-stage valid/ready pipeline that packs instruction
// fields into an RV32I word, flags bad immediates, and counts output beats.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready combinational from out_ready)
//   fmt..imm              : input beat fields
//   out_valid / out_ready : output handshake
//   instruction, imm_err  : encoded word and its error flag
//   enc_count, err_count  : saturating counts of output handshakes (all / erroneous)
module instruction_encoder
   import rv32i_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int CntWidth  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           fmt,
   input  logic [6:0]           opcode,
   input  logic [4:0]           rd,
   input  logic [4:0]           rs1,
   input  logic [4:0]           rs2,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic [DataWidth-1:0] imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DataWidth-1:0] instruction,
   output logic                 imm_err,
   output logic [CntWidth-1:0]  enc_count,
   output logic [CntWidth-1:0]  err_count
);

   enc_req_t               in_req;
   enc_req_t               s1_req;
   logic                   s1_valid;
   logic                   s1_en;
   logic                   s2_en;
   logic [DataWidth-1:0]   pack_word;
   logic                   pack_err;
   logic                   out_fire;

   assign in_req = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                     funct3: funct3, funct7: funct7, imm: imm};

   // Each stage advances when its successor is empty or draining, so bubbles
   // collapse and a full pipe still moves one beat per cycle.
   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;
   assign out_fire = out_valid && out_ready;

   instr_field_pack #(.DataWidth(DataWidth)) u_pack (
      .fmt         (s1_req.fmt),
      .opcode      (s1_req.opcode),
      .rd          (s1_req.rd),
      .rs1         (s1_req.rs1),
      .rs2         (s1_req.rs2),
      .funct3      (s1_req.funct3),
      .funct7      (s1_req.funct7),
      .imm         (s1_req.imm),
      .instruction (pack_word),
      .imm_err     (pack_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_req      <= '0;
         out_valid   <= 1'b0;
         instruction <= '0;
         imm_err     <= 1'b0;
         enc_count   <= '0;
         err_count   <= '0;
      end else begin
         if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) s1_req <= in_req;
         end
         if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               instruction <= pack_word;
               imm_err     <= pack_err;
            end
         end
         if (out_fire) begin
            if (enc_count != '1)           enc_count <= enc_count + 1'b1;
            if (imm_err && err_count != '1) err_count <= err_count + 1'b1;
         end
      end
   end

endmodule
